// File: rtl/tenyr_pkg.sv
// Shared types and constants for the tenyr storage subsystem.
// Provides word/register-index types, special register indices and a window-hit helper.
package tenyr_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  reg_idx_t;

    localparam reg_idx_t REG_PC   = 4'd15;
    localparam reg_idx_t REG_ZERO = 4'd0;

    localparam word_t MEM0_BASE_DEF = 32'd0;
    localparam word_t MEM0_SIZE_DEF = 32'd4;
    localparam word_t MEM1_BASE_DEF = 32'd4;
    localparam word_t MEM1_SIZE_DEF = 32'd4;
    localparam word_t SER_BASE_DEF  = 32'd8;

    // Unsigned subtraction wraps addresses below base to huge
    // offsets, so one compare covers both window bounds.
    function automatic logic in_window(word_t a, word_t base, word_t size);
        word_t off;
        off = a - base;
        return off < size;
    endfunction

endpackage

// File: rtl/tenyr_storage_if.sv
// Data-port bus between the CPU datapath and tenyr_storage.
// master: drives d_en/d_we/d_addr/d_wdata, receives d_rdata; slave: the reverse.
interface tenyr_storage_if;
    import tenyr_pkg::*;

    logic  d_en;
    logic  d_we;
    word_t d_addr;
    word_t d_wdata;
    word_t d_rdata;

    modport master (
        output d_en,
        output d_we,
        output d_addr,
        output d_wdata,
        input  d_rdata
    );

    modport slave (
        input  d_en,
        input  d_we,
        input  d_addr,
        input  d_wdata,
        output d_rdata
    );

endinterface

// File: rtl/tenyr_storage_mem_bank.sv
// mem_bank: one windowed word memory with a write port, a data read port and a fetch read port.
// Ports: clk, reset_n, we/addr/wdata (store), rdata/hit (data read), f_addr/f_data/f_hit (fetch).
module mem_bank
    import tenyr_pkg::*;
#(
    parameter word_t BASE = 32'd0,
    parameter word_t SIZE = 32'd4
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  we,
    input  word_t addr,
    input  word_t wdata,
    output word_t rdata,
    output logic  hit,
    input  word_t f_addr,
    output word_t f_data,
    output logic  f_hit
);

    localparam int DEPTH = int'(SIZE);
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    word_t          mem [DEPTH];
    word_t          d_off;
    word_t          f_off;
    logic [IW-1:0]  d_idx;
    logic [IW-1:0]  f_idx;

    assign d_off = addr - BASE;
    assign f_off = f_addr - BASE;
    assign d_idx = d_off[IW-1:0];
    assign f_idx = f_off[IW-1:0];

    assign hit   = in_window(addr, BASE, SIZE);
    assign f_hit = in_window(f_addr, BASE, SIZE);

    assign rdata  = hit   ? mem[d_idx] : '0;
    assign f_data = f_hit ? mem[f_idx] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && hit) begin
            mem[d_idx] <= wdata;
        end
    end

endmodule

// File: rtl/tenyr_storage.sv
// tenyr_storage: 16x32 register file (r15 = pc), two windowed memory banks, serial TX register.
// Ports: clk, reset_n, dbus (data port, slave), i_data, rf_* (ports X/Y/Z), pc, tx_valid, tx_data.
// Define TENYR_SERIAL_PRINT_EN to also echo each serial byte with $write in simulation.
module tenyr_storage
    import tenyr_pkg::*;
#(
    parameter word_t MEM0_BASE = MEM0_BASE_DEF,
    parameter word_t MEM0_SIZE = MEM0_SIZE_DEF,
    parameter word_t MEM1_BASE = MEM1_BASE_DEF,
    parameter word_t MEM1_SIZE = MEM1_SIZE_DEF,
    parameter word_t SER_BASE  = SER_BASE_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    tenyr_storage_if.slave         dbus,
    output word_t                  i_data,
    input  logic                   rf_we,
    input  reg_idx_t               rf_idx_z,
    input  word_t                  rf_wdata_z,
    output word_t                  rf_rdata_z,
    input  reg_idx_t               rf_idx_x,
    output word_t                  rf_rdata_x,
    input  reg_idx_t               rf_idx_y,
    output word_t                  rf_rdata_y,
    output word_t                  pc,
    output logic                   tx_valid,
    output logic [7:0]             tx_data
);

    word_t regs [16];

    logic  st_req;
    logic  ld_req;
    logic  ser_hit;
    logic  ser_wr;
    logic  bank_st;

    logic  hit0;
    logic  hit1;
    logic  f_hit0;
    logic  f_hit1;
    word_t rd0;
    word_t rd1;
    word_t fd0;
    word_t fd1;

    function automatic word_t rf_read(reg_idx_t idx, word_t v);
        return (idx == REG_ZERO) ? '0 : v;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (rf_we && rf_idx_z != REG_ZERO) begin
            regs[rf_idx_z] <= rf_wdata_z;
        end
    end

    assign rf_rdata_x = rf_read(rf_idx_x, regs[rf_idx_x]);
    assign rf_rdata_y = rf_read(rf_idx_y, regs[rf_idx_y]);
    assign rf_rdata_z = rf_read(rf_idx_z, regs[rf_idx_z]);
    assign pc         = regs[REG_PC];

    assign st_req  = dbus.d_en && dbus.d_we;
    assign ld_req  = dbus.d_en && !dbus.d_we;
    assign ser_hit = (dbus.d_addr == SER_BASE);
    assign ser_wr  = st_req && ser_hit;
    assign bank_st = st_req && !ser_hit;

    mem_bank #(
        .BASE (MEM0_BASE),
        .SIZE (MEM0_SIZE)
    ) u_bank0 (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (bank_st),
        .addr    (dbus.d_addr),
        .wdata   (dbus.d_wdata),
        .rdata   (rd0),
        .hit     (hit0),
        .f_addr  (pc),
        .f_data  (fd0),
        .f_hit   (f_hit0)
    );

    // Bank0 has priority when windows overlap, so bank1
    // must not also take a store that bank0 claimed.
    mem_bank #(
        .BASE (MEM1_BASE),
        .SIZE (MEM1_SIZE)
    ) u_bank1 (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (bank_st && !hit0),
        .addr    (dbus.d_addr),
        .wdata   (dbus.d_wdata),
        .rdata   (rd1),
        .hit     (hit1),
        .f_addr  (pc),
        .f_data  (fd1),
        .f_hit   (f_hit1)
    );

    always_comb begin
        dbus.d_rdata = '0;
        if (ld_req && !ser_hit) begin
            unique case (1'b1)
                hit0:    dbus.d_rdata = rd0;
                hit1:    dbus.d_rdata = rd1;
                default: dbus.d_rdata = '0;
            endcase
        end
    end

    always_comb begin
        i_data = '0;
        unique case (1'b1)
            f_hit0:  i_data = fd0;
            f_hit1:  i_data = fd1;
            default: i_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_valid <= ser_wr;
            if (ser_wr) begin
                tx_data <= dbus.d_wdata[7:0];
            end
        end
    end

`ifdef TENYR_SERIAL_PRINT_EN
    always_ff @(posedge clk) begin
        if (reset_n && ser_wr) begin
            $write("%c", dbus.d_wdata[7:0]);
        end
    end
`else
    // Without the print option a serial store is visible only on tx_valid/tx_data.
`endif

endmodule

// File: tb/tb_tenyr_storage.sv
// Self-checking bench for tenyr_storage: directed cases plus randomized traffic
// compared every cycle against a flat-array behavioural model.
module tb_tenyr_storage;
    import tenyr_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rf_we;
    reg_idx_t   rf_idx_z;
    reg_idx_t   rf_idx_x;
    reg_idx_t   rf_idx_y;
    word_t      rf_wdata_z;
    word_t      rf_rdata_z;
    word_t      rf_rdata_x;
    word_t      rf_rdata_y;
    word_t      i_data;
    word_t      pc;
    logic       tx_valid;
    logic [7:0] tx_data;

    always #5 clk = ~clk;

    tenyr_storage_if dbus ();

    tenyr_storage dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dbus       (dbus.slave),
        .i_data     (i_data),
        .rf_we      (rf_we),
        .rf_idx_z   (rf_idx_z),
        .rf_wdata_z (rf_wdata_z),
        .rf_rdata_z (rf_rdata_z),
        .rf_idx_x   (rf_idx_x),
        .rf_rdata_x (rf_rdata_x),
        .rf_idx_y   (rf_idx_y),
        .rf_rdata_y (rf_rdata_y),
        .pc         (pc),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: banks 0..3 and 4..7 are contiguous, so one flat
    // array indexed by the word address describes both.
    word_t      m_mem [8];
    word_t      m_reg [16];
    logic       m_txv;
    logic [7:0] m_txd;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic word_t m_rd(reg_idx_t idx);
        return (idx == 0) ? 32'd0 : m_reg[idx];
    endfunction

    function automatic word_t m_mem_at(word_t a);
        return (a < 32'd8) ? m_mem[a[2:0]] : 32'd0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        m_txv = 1'b0;
        m_txd = '0;
    endtask

    task automatic m_edge();
        logic st;
        st = dbus.d_en && dbus.d_we;
        if (rf_we && rf_idx_z != 0) m_reg[rf_idx_z] = rf_wdata_z;
        if (st && dbus.d_addr < 32'd8) m_mem[dbus.d_addr[2:0]] = dbus.d_wdata;
        m_txv = st && (dbus.d_addr == 32'd8);
        if (m_txv) m_txd = dbus.d_wdata[7:0];
    endtask

    task automatic check_all();
        word_t exp_ld;
        exp_ld = (dbus.d_en && !dbus.d_we) ? m_mem_at(dbus.d_addr) : 32'd0;
        chk("d_rdata", dbus.d_rdata, exp_ld);
        chk("i_data", i_data, m_mem_at(m_reg[15]));
        chk("pc", pc, m_reg[15]);
        chk("rf_x", rf_rdata_x, m_rd(rf_idx_x));
        chk("rf_y", rf_rdata_y, m_rd(rf_idx_y));
        chk("rf_z", rf_rdata_z, m_rd(rf_idx_z));
        chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_txv});
        chk("tx_data", {24'd0, tx_data}, {24'd0, m_txd});
    endtask

    task automatic dset(logic en, logic we, word_t a, word_t wd);
        dbus.d_en    = en;
        dbus.d_we    = we;
        dbus.d_addr  = a;
        dbus.d_wdata = wd;
    endtask

    task automatic rset(logic we, reg_idx_t iz, word_t wz,
                        reg_idx_t ix, reg_idx_t iy);
        rf_we      = we;
        rf_idx_z   = iz;
        rf_wdata_z = wz;
        rf_idx_x   = ix;
        rf_idx_y   = iy;
    endtask

    task automatic sample();
        #4;
        check_all();
    endtask

    task automatic edge_();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    function automatic word_t rnd_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return word_t'($urandom_range(0, 9));
        if (r == 7) return 32'd100;
        if (r == 8) return 32'hFFFF_FFFF;
        return word_t'($urandom);
    endfunction

    initial begin
        m_reset();
        dset(0, 0, 0, 0);
        rset(0, 0, 0, 0, 0);
        #12;
        check_all();
        chk("rst_pc", pc, 32'd0);
        chk("rst_txv", {31'd0, tx_valid}, 32'd0);
        reset_n = 1'b1;
        edge_();

        dset(1, 1, 2, 3);   sample(); edge_();
        dset(1, 1, 5, 6);   sample(); edge_();
        dset(1, 0, 2, 0);   sample(); chk("ld2", dbus.d_rdata, 32'd3); edge_();
        dset(1, 0, 5, 0);   sample(); chk("ld5", dbus.d_rdata, 32'd6); edge_();

        dset(1, 1, 8, 65);  sample(); edge_();
        dset(0, 0, 0, 0);   sample();
        chk("tx_hi", {31'd0, tx_valid}, 32'd1);
        chk("tx_A", {24'd0, tx_data}, 32'h41);
        edge_();
        sample(); chk("tx_lo", {31'd0, tx_valid}, 32'd0); edge_();
        dset(1, 0, 8, 0);   sample(); chk("ld8", dbus.d_rdata, 32'd0); edge_();

        dset(0, 0, 0, 0);
        rset(1, 2, 3, 0, 0); sample(); chk("z_old", rf_rdata_z, 32'd0); edge_();
        rset(1, 5, 6, 0, 0); sample(); edge_();
        rset(0, 2, 0, 2, 5); sample();
        chk("rx2", rf_rdata_x, 32'd3);
        chk("ry5", rf_rdata_y, 32'd6);
        edge_();
        rset(1, 0, 7, 2, 5); sample(); edge_();
        rset(0, 0, 0, 2, 5); sample(); chk("r0", rf_rdata_z, 32'd0); edge_();
        rset(1, 15, 5, 2, 5); sample(); edge_();
        rset(0, 15, 0, 2, 5); sample();
        chk("pc5", pc, 32'd5);
        chk("i5", i_data, 32'd6);
        edge_();

        dset(1, 0, 100, 0); sample(); chk("ld100", dbus.d_rdata, 32'd0); edge_();
        dset(0, 0, 2, 0);   sample(); chk("ld_off", dbus.d_rdata, 32'd0); edge_();
        dset(1, 1, 100, 32'hDEAD); sample(); edge_();
        dset(1, 0, 2, 0);   sample(); chk("keep2", dbus.d_rdata, 32'd3); edge_();
        dset(1, 0, 5, 0);   sample(); chk("keep5", dbus.d_rdata, 32'd6); edge_();

        for (int c = 0; c < 2000; c++) begin
            dset(1'($urandom_range(0, 3) != 0), 1'($urandom),
                 rnd_addr(), $urandom);
            rset(1'($urandom_range(0, 2) == 0), 4'($urandom),
                 ($urandom_range(0, 1) != 0) ? word_t'($urandom_range(0, 9))
                                             : word_t'($urandom),
                 4'($urandom), 4'($urandom));
            sample();
            edge_();
        end

        dset(1, 1, 2, 32'h1234);
        rset(1, 2, 9, 2, 0);
        sample(); edge_();
        rset(1, 15, 2, 2, 0);
        dset(1, 1, 8, 32'h5A);
        sample(); edge_();
        dset(1, 0, 2, 0);
        rset(0, 2, 0, 2, 0);
        chk("pre_rst_txv", {31'd0, tx_valid}, 32'd1);
        chk("pre_rst_i", i_data, 32'h1234);
        #2 reset_n = 1'b0;
        #1;
        chk("async_r2", rf_rdata_x, 32'd0);
        chk("async_pc", pc, 32'd0);
        chk("async_txv", {31'd0, tx_valid}, 32'd0);
        chk("async_mem", dbus.d_rdata, 32'd0);
        m_reset();
        sample();
        reset_n = 1'b1;
        edge_();
        sample();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
